// File: rtl/serial_pkg.sv
// Shared serial-line definitions for the transmit arbiter and receiver.
// Frame: one start bit, DATA_BITS data bits LSB first, one stop bit.
package serial_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector.
// last names the requester served most recently; the other one wins ties.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] gnt
);

  assign gnt[0] = enable & req[0] & (~req[1] | last);
  assign gnt[1] = enable & req[1] & (~req[0] | ~last);

endmodule

// File: rtl/serial_tx_arb.sv
// Two-requester byte arbiter feeding a single idle-high serial line.
// One bit per clock; back-to-back frames are accepted in the STOP cycle.
module serial_tx_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       out,
  output logic       busy,
  output logic       grant_id,
  output logic       done
);

  import serial_pkg::*;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e            state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0]           bit_cnt;
  logic                 last;
  logic                 window;
  logic [1:0]           gnt;
  logic                 accept;

  assign window = ~reset & ((state == IDLE) | (state == STOP));

  rr_arb2 u_arb (
    .req    ({req1_valid, req0_valid}),
    .last   (last),
    .enable (window),
    .gnt    (gnt)
  );

  assign accept     = |gnt;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign busy       = (state != IDLE);
  assign done       = (state == STOP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out       <= STOP_BIT;
      grant_id  <= 1'b0;
      bit_cnt   <= 3'd0;
      shift_reg <= '0;
      last      <= 1'b1;
    end else begin
      unique case (state)
        IDLE, STOP: begin
          if (accept) begin
            state     <= START;
            out       <= START_BIT;
            shift_reg <= gnt[1] ? req1_data : req0_data;
            grant_id  <= gnt[1];
            last      <= gnt[1];
          end else begin
            state <= IDLE;
            out   <= STOP_BIT;
          end
        end
        START: begin
          state     <= DATA;
          out       <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= 3'd0;
        end
        DATA: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) begin
            state <= STOP;
            out   <= STOP_BIT;
          end else begin
            out       <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        default: begin
          state <= IDLE;
          out   <= STOP_BIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arb.sv
// Bench for serial_tx_arb: vector table plus hand sequences,
// with a frame scoreboard and arbitration model on the falling edge.
module tb_serial_tx_arb;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       out;
  logic       busy;
  logic       grant_id;
  logic       done;

  always #5 clk = ~clk;

  serial_tx_arb dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out        (out),
    .busy       (busy),
    .grant_id   (grant_id),
    .done       (done)
  );

  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       id;
  } vec_t;

  exp_t sbq[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   mcnt = 0;
  logic mptr = 1'b1;
  int   r0n = 0;
  int   r1n = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout/empty want event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    tick();
    while (mcnt != 1 && n < 40) begin
      tick();
      n++;
    end
    if (mcnt != 1) fail(name);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) fail(name);
  endtask

  // mcnt: 0 idle, 1 start, 2..9 data, 10 stop
  always @(negedge clk) begin
    logic e0, e1, win;
    if (mcnt == 0) begin
      chk("idle_out", out, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end else begin
      if (mcnt == 1) begin
        if (sbq.size() == 0) begin
          fail("sb_empty");
          cur = '0;
        end else begin
          cur = sbq.pop_front();
        end
        chk("start_bit", out, 0);
        chk("grant_id", grant_id, cur.id);
      end else if (mcnt <= 9) begin
        chk("data_bit", out, cur.data[3'(mcnt-2)]);
      end else begin
        chk("stop_bit", out, 1);
      end
      chk("busy", busy, 1);
      chk("done", done, mcnt == 10);
    end
    win = !reset && (mcnt == 0 || mcnt == 10);
    e0 = win && req0_valid && (!req1_valid || mptr);
    e1 = win && req1_valid && (!req0_valid || !mptr);
    chk("ready0", req0_ready, e0);
    chk("ready1", req1_ready, e1);
    if (req0_ready && req0_valid) r0n++;
    if (req1_ready && req1_valid) r1n++;
    if (reset) begin
      mcnt = 0;
      mptr = 1'b1;
    end else if (e0 || e1) begin
      sbq.push_back({e1, e1 ? req1_data : req0_data});
      mptr = e1;
      mcnt = 1;
    end else if (mcnt == 0 || mcnt == 10) begin
      mcnt = 0;
    end else begin
      mcnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    vec_t       vt[6];
    logic [7:0] col;
    int         n;

    vt[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0};
    vt[1] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1};
    vt[2] = '{1'b1, 8'h0F, 1'b1, 8'hF0, 1'b0};
    vt[3] = '{1'b1, 8'h55, 1'b1, 8'hAA, 1'b1};
    vt[4] = '{1'b1, 8'h00, 1'b1, 8'hFF, 1'b0};
    vt[5] = '{1'b0, 8'h00, 1'b1, 8'h81, 1'b1};

    tick();
    tick();
    reset = 1'b0;
    chk("rst_out", out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_grant", grant_id, 0);
    tick();

    // tie after reset, second frame back-to-back
    req0_valid = 1'b1;
    req0_data  = 8'h01;
    req1_valid = 1'b1;
    req1_data  = 8'h80;
    wait_start("tie_acc");
    chk("tie_first", grant_id, 0);
    req0_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      n++;
      if (n == 11) begin
        chk("tie_second", grant_id, 1);
        chk("b2b_start", out, 0);
        req1_valid = 1'b0;
      end
      tick();
    end
    chk("tie_span", n, 20);
    tick();

    foreach (vt[i]) begin
      req0_valid = vt[i].v0;
      req0_data  = vt[i].d0;
      req1_valid = vt[i].v1;
      req1_data  = vt[i].d1;
      wait_start("vec_acc");
      chk("vec_grant", grant_id, vt[i].id);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle("vec_idle");
      tick();
    end

    // fairness over six frames
    r0n = 0;
    r1n = 0;
    n = 0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'h12;
    req1_data  = 8'h34;
    for (int i = 0; i < 100 && n < 6; i++) begin
      tick();
      if (mcnt == 1) begin
        chk("fair_order", grant_id, n[0]);
        n++;
        req0_data = req0_data + 8'd1;
        req1_data = req1_data + 8'd1;
        if (n == 6) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
    end
    if (n != 6) fail("fair_timeout");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle("fair_idle");
    chk("fair_r0", r0n, 3);
    chk("fair_r1", r1n, 3);
    tick();

    // data change after accept
    req0_valid = 1'b1;
    req0_data  = 8'hFF;
    wait_start("stab_acc");
    req0_valid = 1'b0;
    col = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if (mcnt >= 2 && mcnt <= 9) col[3'(mcnt-2)] = out;
      if (mcnt == 4) req0_data = 8'h00;
      tick();
    end
    chk("stab_byte", col, 8'hFF);
    wait_idle("stab_idle");
    tick();

    // reset in the 4th data cycle
    req0_valid = 1'b1;
    req0_data  = 8'hC3;
    wait_start("mid_acc");
    req0_valid = 1'b0;
    n = 0;
    while (mcnt != 5 && n < 20) begin
      tick();
      n++;
    end
    if (mcnt != 5) fail("mid_reach");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_out", out, 1);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) n++;
      tick();
    end
    chk("mid_nodone", n, 0);
    req0_valid = 1'b1;
    req0_data  = 8'h5A;
    req1_valid = 1'b1;
    req1_data  = 8'hA5;
    wait_start("mid_tie");
    chk("mid_tie_grant", grant_id, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle("mid_idle");
    tick();

    // gapped traffic from requester 1 only
    for (int k = 0; k < 3; k++) begin
      req1_valid = 1'b1;
      req1_data  = 8'(8'h30 + k);
      wait_start("gap_acc");
      chk("gap_grant", grant_id, 1);
      req1_valid = 1'b0;
      wait_idle("gap_idle");
      for (int j = 0; j < 3; j++) begin
        chk("gap_out", out, 1);
        chk("gap_busy", busy, 0);
        tick();
      end
    end
    req0_valid = 1'b1;
    req0_data  = 8'h99;
    req1_valid = 1'b1;
    req1_data  = 8'h66;
    wait_start("gap_tie");
    chk("gap_ptr", grant_id, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle("gap_tie_idle");
    tick();
    tick();

    if (sbq.size() != 0) fail("sb_left");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_tx_arb.md
SERIAL_TX_ARB -- requirements
Module: serial_tx_arb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  sole clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a byte to send.
REQ-005 req0_data  input  8  requester 0 byte.
REQ-006 req0_ready  output  1  requester 0 byte accepted this cycle when req0_valid is also high.
REQ-007 req1_valid, req1_data, req1_ready SHALL have the same directions, widths and meanings as the requester 0 ports.
REQ-008 out  output  1  serial line, registered, idle-high.
REQ-009 busy  output  1  a frame is in flight (START, DATA or STOP).
REQ-010 grant_id  output  1  requester whose frame is on the line; valid while busy.
REQ-011 done  output  1  high for exactly the STOP-bit cycle of each frame.

Function
REQ-012 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), one bit per clk cycle, 10 cycles per frame.
REQ-013 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-014 FSM transitions SHALL be: IDLE->START on accept; START->DATA; DATA->DATA until 8 bits are sent, then DATA->STOP; STOP->START on accept, otherwise STOP->IDLE.
REQ-015 An accept window SHALL exist only in IDLE and STOP; reqN_ready SHALL be combinational and high only for the arbitration winner inside that window.
REQ-016 Arbitration SHALL be round-robin with a 1-bit last-served pointer: a single valid requester wins; if both are valid, the requester not last served wins.
REQ-017 On accept, the block SHALL latch the winner's data into an 8-bit shift register, set grant_id, and update the pointer to the winner.
REQ-018 out SHALL be 0 in the START cycle, shift_reg[0] in each DATA cycle (shifting right after each), and 1 in the STOP and IDLE cycles.
REQ-019 A 3-bit bit counter SHALL clear in START and increment in DATA; DATA SHALL exit when the counter equals 7.
REQ-020 An accept in the STOP cycle SHALL place the next start bit in the immediately following cycle, with no idle gap between frames.
REQ-021 Changes to reqN_data or reqN_valid after accept SHALL NOT affect the frame in flight.
REQ-022 A requester that deasserts valid without being accepted SHALL lose nothing, and the pointer SHALL be unchanged.
REQ-023 Latency SHALL be: the start bit appears on out exactly 1 cycle after the accepting edge.
REQ-024 done SHALL equal (state==STOP); busy SHALL equal (state!=IDLE).

Reset
REQ-025 On reset the block SHALL set state=IDLE, out=1, busy=0, done=0, grant_id=0, bit counter=0, shift register=0, and pointer=1, so requester 0 wins the first tie.
REQ-026 Reset asserted mid-frame SHALL abandon the frame, drive out=1 from the next cycle, and SHALL NOT assert done for the abandoned frame.
REQ-027 reqN_ready SHALL be 0 during any cycle in which reset is high.

Structure
REQ-028 A shared package serial_pkg SHALL hold the state enum (IDLE, START, DATA, STOP), DATA_BITS=8, and the START_BIT=0 and STOP_BIT=1 constants, for reuse by the receiver.
REQ-029 Two-way round-robin selection SHALL be a sub-module rr_arb2, with inputs req[1:0], last and enable and outputs gnt[1:0]; the serializer FSM SHALL stay in serial_tx_arb.

Verification
REQ-030 Single request: req0 sends 8'hA5 from IDLE -> out shows 0,1,0,1,0,0,1,0,1,1 over 10 cycles; done high in cycle 10 only; grant_id=0.
REQ-031 Tie after reset: both valid with 8'h01 and 8'h80 -> req0 is sent first, then req1 back-to-back, with the second start bit directly after the first stop bit (20 contiguous cycles).
REQ-032 Fairness: both requesters held valid for 6 frames -> grant order 0,1,0,1,0,1, and each reqN_ready pulses exactly 3 times.
REQ-033 Data stability: req0_data changes from 8'hFF to 8'h00 during DATA -> the line still carries 8'hFF.
REQ-034 Reset mid-frame: reset asserted in the 4th DATA cycle -> out=1 the next cycle, no done pulse, and req0 wins the next tie.
REQ-035 Gapped traffic: req1 valid alone, with 3 idle cycles between bytes -> out holds 1 in the gaps, busy=0 in the gaps, and the pointer settles on 1.
